// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads instrBytes bytes per instruction over a cs/readmem/memDataReady
// memory port, assembles them big-endian and hands the result to the core over valid/ready.
module instruction_fetch_unit #(
    parameter int dataWidth     = 8,
    parameter int addrWidth     = 12,
    parameter int instrBytes    = 2,
    parameter int timeoutCycles = 64,
    parameter logic [addrWidth-1:0] resetPC = {addrWidth{1'b0}}
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic                            cs,
    output logic                            readmem,
    output logic [addrWidth-1:0]            address,
    input  logic [dataWidth-1:0]            dataIn,
    input  logic                            memDataReady,
    output logic [dataWidth*instrBytes-1:0] instr,
    output logic [addrWidth-1:0]            instrPC,
    output logic                            instrValid,
    input  logic                            instrReady,
    input  logic                            jumpEn,
    input  logic [addrWidth-1:0]            jumpAddr,
    output logic                            fetchErr,
    output logic                            busy
);

    localparam int IW  = dataWidth * instrBytes;
    localparam int BCW = (instrBytes > 1) ? $clog2(instrBytes) : 1;
    localparam int TCW = $clog2(timeoutCycles + 1);

    localparam logic [1:0] ST_GAP  = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(instrBytes - 1);
    localparam logic [TCW-1:0] TO_LIMIT  = TCW'(timeoutCycles);

    logic [1:0]           state_q, state_d;
    logic [addrWidth-1:0] pc_q, pc_d;
    logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [TCW-1:0]       to_cnt_q, to_cnt_d;
    logic                 sync1_q, sync2_q, rdy_prev_q, rdy_prev_d;
    logic [IW-1:0]        instr_q, instr_d;
    logic [addrWidth-1:0] instr_pc_q, instr_pc_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic                 ready_edge_s;

    assign ready_edge_s = sync2_q & ~rdy_prev_q;

    // Next-state logic; jumpEn overrides everything at the end.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        // Outside REQ the edge detector is primed high, so a ready pulse left over from an
        // aborted access cannot register as a fresh edge in the next REQ.
        if (state_q == ST_REQ) begin
            rdy_prev_d = sync2_q;
        end else begin
            rdy_prev_d = 1'b1;
        end

        case (state_q)
            ST_GAP: begin
                to_cnt_d = {TCW{1'b0}};
                state_d  = ST_REQ;
                if (byte_cnt_q == {BCW{1'b0}}) begin
                    instr_pc_d = pc_q;
                end else begin
                    instr_pc_d = instr_pc_q;
                end
            end
            ST_REQ: begin
                if (to_cnt_q == TO_LIMIT) begin
                    to_cnt_d = to_cnt_q;
                end else begin
                    to_cnt_d = to_cnt_q + TCW'(1);
                end
                if (ready_edge_s) begin
                    for (int b = 0; b < instrBytes; b++) begin
                        if (BCW'(b) == byte_cnt_q) begin
                            instr_d[(instrBytes-1-b)*dataWidth +: dataWidth] = dataIn;
                        end else begin
                            instr_d[(instrBytes-1-b)*dataWidth +: dataWidth] =
                                instr_q[(instrBytes-1-b)*dataWidth +: dataWidth];
                        end
                    end
                    pc_d     = pc_q + addrWidth'(1);
                    to_cnt_d = {TCW{1'b0}};
                    if (byte_cnt_q == LAST_BYTE) begin
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        state_d    = ST_GAP;
                    end
                end else if (to_cnt_d == TO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (instrReady) begin
                    valid_d    = 1'b0;
                    byte_cnt_d = {BCW{1'b0}};
                    state_d    = ST_GAP;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_ERR: begin
                err_d   = 1'b1;
                valid_d = 1'b0;
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_GAP;
            end
        endcase

        if (jumpEn) begin
            pc_d       = jumpAddr;
            byte_cnt_d = {BCW{1'b0}};
            to_cnt_d   = {TCW{1'b0}};
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            valid_d    = 1'b0;
            err_d      = 1'b0;
            state_d    = ST_GAP;
        end else begin
            state_d = state_d;
        end

        req_d  = (state_d == ST_REQ);
        busy_d = (state_d == ST_REQ) || (state_d == ST_GAP);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_GAP;
            pc_q       <= resetPC;
            byte_cnt_q <= {BCW{1'b0}};
            to_cnt_q   <= {TCW{1'b0}};
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            rdy_prev_q <= 1'b0;
            instr_q    <= {IW{1'b0}};
            instr_pc_q <= resetPC;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            sync1_q    <= memDataReady;
            sync2_q    <= sync1_q;
            rdy_prev_q <= rdy_prev_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
        end
    end

    assign cs         = req_q;
    assign readmem    = req_q;
    assign address    = pc_q;
    assign instr      = instr_q;
    assign instrPC    = instr_pc_q;
    assign instrValid = valid_q;
    assign fetchErr   = err_q;
    assign busy       = busy_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Clocked initiator for the instruction memory's cs/readmem/address/memDataReady read interface.
- Owns the program counter and issues one byte read per memory access.
- Assembles instrBytes consecutive bytes into one instruction and presents it to the CPU core over a valid/ready handshake.
- Supports jump redirect and a timeout that flags a memory that never answers.

Parameters:
- dataWidth, 8, memory data width in bits.
- addrWidth, 12, memory address width in bits.
- instrBytes, 2, memory words per instruction (1..4).
- timeoutCycles, 64, clk cycles allowed in REQ before error.
- resetPC, 0, PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  output  1  memory chip select.
- readmem  output  1  memory read strobe.
- address  output  addrWidth  memory byte address.
- dataIn  input  dataWidth  memory dataOut; valid while cs&&readmem.
- memDataReady  input  1  asynchronous ready pulse from memory.
- instr  output  dataWidth*instrBytes  assembled instruction.
- instrPC  output  addrWidth  address of the instruction's first byte.
- instrValid  output  1  instr/instrPC valid.
- instrReady  input  1  core accepts instruction.
- jumpEn  input  1  redirect request, one-cycle pulse.
- jumpAddr  input  addrWidth  redirect target.
- fetchErr  output  1  sticky timeout flag.
- busy  output  1  high in REQ or GAP.

Behaviour:
Reset (rst_n low, asynchronous):
- cs=0, readmem=0, address=resetPC, instr=0, instrPC=resetPC, instrValid=0, fetchErr=0, busy=0.
- Byte counter=0, timeout counter=0, synchronizer flops=0, state=GAP.
- Reset mid-read drops cs/readmem immediately. Any in-flight byte is discarded.

memDataReady handling:
- Passes through a 2-flop synchronizer, then a rising-edge detector producing a one-cycle readyEdge.
- The memory's ready pulse must last at least 2 clk periods. The bench uses clk=10ns against timer=5ns, cycle=25ns.

States:
- GAP:
  - cs=0, readmem=0 for exactly one cycle, so the memory re-arms even when the address is unchanged.
  - Next state is REQ.
- REQ:
  - cs=1, readmem=1, address=PC, held stable. The timeout counter increments each cycle.
  - On readyEdge: capture dataIn into byte slot byteCnt. The first byte goes to the most significant position (big-endian). PC<=PC+1 modulo 2^addrWidth; 0xFFF wraps to 0x000.
    - If byteCnt==instrBytes-1: go to HOLD.
    - Otherwise: byteCnt++ and go to GAP.
  - If the timeout counter reaches timeoutCycles with no readyEdge: go to ERR.
- HOLD:
  - cs=0, readmem=0, instrValid=1. instr and instrPC are stable until accepted.
  - On instrValid&&instrReady: instrValid<=0, byteCnt<=0, go to GAP.
- ERR:
  - cs=0, readmem=0, fetchErr=1, instrValid=0.
  - Only jumpEn or reset leaves ERR.

Cycle rules:
- instrPC is latched as PC at the start of byte 0 of each instruction.
- Latency per byte = cycles to ready rise + 2 sync + 1 capture + 1 GAP.
- The first instrValid appears no earlier than (instrBytes*4) cycles after reset release.

jumpEn (any state, highest priority):
- Next cycle: PC<=jumpAddr, byteCnt<=0, timeout counter<=0, instrValid<=0, fetchErr<=0, state<=GAP.
- Any partial instruction is discarded.
- jumpEn concurrent with an accepted handshake in HOLD: the handshake completes (the core consumed the instruction), then the redirect applies.
- jumpEn concurrent with readyEdge in REQ: the byte is discarded and the PC is not incremented past jumpAddr.

Widths:
- The timeout counter is clog2(timeoutCycles+1) bits and saturates.
- byteCnt is clog2(instrBytes) bits, minimum 1.

Test Plan:
1. Release reset, memory holds bytes 0x12,0x34 at addresses 0,1, instrReady=1 -> instrValid pulses with instr=0x1234, instrPC=0. Second instruction has instrPC=2. cs/readmem drop for exactly 1 cycle between bytes.
2. instrReady held low for 10 cycles with instrValid=1 -> instr and instrPC stay stable, no cs activity. Raising instrReady for one cycle -> exactly one instruction consumed.
3. Memory never pulses memDataReady -> fetchErr=1 after 64 cycles in REQ, cs=0. Then jumpEn with jumpAddr=0x100 -> fetchErr=0, next read at address 0x100.
4. jumpEn with jumpAddr=0x0A0 while byte 1 of an instruction is in REQ -> partial discarded, next instrPC=0x0A0 with bytes from 0x0A0/0x0A1.
5. jumpAddr=0xFFF -> instr built from bytes at 0xFFF,0x000, instrPC=0xFFF, next instrPC=0x001.
6. rst_n asserted while cs=1 mid-read -> cs, readmem and instrValid go 0 immediately without a clock edge. After release, fetch restarts at resetPC.
